decode_stage_pipe: RTL and testbench

//  Pipelined, parametrised instruction decode stage with integrated register file.

---
 rtl/decode_stage_pipe_if.sv | 34 +++
 rtl/decode_stage_pipe.sv | 100 ++++++++++
 tb/tb_decode_stage_pipe.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_pipe_if.sv
// decode_stage_pipe_if: fetch-side request, writeback port and decoded result slot of the decode stage
interface decode_stage_pipe_if #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int ERRCNT_W = 8
);
    localparam int AW = $clog2(NREG);
    logic                in_valid;
    logic                in_ready;
    logic [31:0]         komut;
    logic                we;
    logic [AW-1:0]       waddr;
    logic [XLEN-1:0]     wdata;
    logic                out_valid;
    logic                out_ready;
    logic [6:0]          opcode;
    logic [3:0]          func;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic [XLEN-1:0]     rs1_data;
    logic [XLEN-1:0]     rs2_data;
    logic [XLEN-1:0]     imm;
    logic                hata;
    logic [ERRCNT_W-1:0] err_count;
    modport master (
        output in_valid, komut, we, waddr, wdata, out_ready,
        input  in_ready, out_valid, opcode, func, rs1, rs2, rd, rs1_data, rs2_data, imm, hata, err_count
    );
    modport slave (
        input  in_valid, komut, we, waddr, wdata, out_ready,
        output in_ready, out_valid, opcode, func, rs1, rs2, rd, rs1_data, rs2_data, imm, hata, err_count
    );
endinterface

// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: R/I/U/B decode with register file read, write bypass and one registered valid/ready slot
module decode_stage_pipe #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int SIGN_EXT = 1,
    parameter int ERRCNT_W = 8
) (
    input logic               clk,
    input logic               reset,
    decode_stage_pipe_if.slave bus
);
    localparam int AW = $clog2(NREG);
    localparam logic [6:0] OP_R = 7'b0000001;
    localparam logic [6:0] OP_I = 7'b0000011;
    localparam logic [6:0] OP_U = 7'b0000111;
    localparam logic [6:0] OP_B = 7'b0001111;

    typedef struct packed {
        logic [6:0]      opcode;
        logic [3:0]      func;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic            hata;
    } slot_t;

    logic                out_valid_q, out_valid_d;
    slot_t               slot_q, slot_d, dec;
    logic [ERRCNT_W-1:0] err_q, err_d;
    logic [XLEN-1:0]     rf_q [NREG];
    logic [XLEN-1:0]     rf_d [NREG];
    logic                is_r, is_i, is_u, is_b, sgn, accept;

    // x0 and out-of-range indices read zero; a same-cycle writeback overrides the stored value
    function automatic logic [XLEN-1:0] rd_op(input logic [4:0] idx);
        return (idx == '0 || 32'(idx) >= NREG) ? '0 :
               (bus.we && 32'(bus.waddr) == 32'(idx)) ? bus.wdata : rf_q[idx[AW-1:0]];
    endfunction

    always_comb begin
        is_r         = bus.komut[6:0] == OP_R;
        is_i         = bus.komut[6:0] == OP_I;
        is_u         = bus.komut[6:0] == OP_U;
        is_b         = bus.komut[6:0] == OP_B;
        sgn          = (SIGN_EXT != 0) && bus.komut[31];
        dec.opcode   = bus.komut[6:0];
        dec.rs1      = (is_r || is_i || is_b) ? bus.komut[19:15] : '0;
        dec.rs2      = (is_r || is_b) ? bus.komut[24:20] : '0;
        dec.rd       = (is_r || is_i || is_u) ? bus.komut[11:7] : '0;
        dec.func     = is_r ? {bus.komut[30], bus.komut[14:12]} :
                       (is_i || is_b) ? {1'b0, bus.komut[14:12]} : '0;
        dec.imm      = is_i ? {{(XLEN-12){sgn}}, bus.komut[31:20]} :
                       is_u ? XLEN'(bus.komut[31:12]) :
                       is_b ? {{(XLEN-13){sgn}}, bus.komut[31:25], bus.komut[11:7], 1'b0} : '0;
        dec.hata     = !(is_r || is_i || is_u || is_b) || 32'(dec.rs1) >= NREG ||
                       32'(dec.rs2) >= NREG || 32'(dec.rd) >= NREG;
        dec.rs1_data = rd_op(dec.rs1);
        dec.rs2_data = rd_op(dec.rs2);
    end

    assign bus.in_ready = !out_valid_q || bus.out_ready;

    always_comb begin
        accept      = bus.in_valid && bus.in_ready;
        out_valid_d = accept || (out_valid_q && !bus.out_ready);
        slot_d      = accept ? dec : slot_q;
        err_d       = (accept && dec.hata && !(&err_q)) ? err_q + ERRCNT_W'(1) : err_q;
        rf_d        = rf_q;
        if (bus.we && bus.waddr != '0 && 32'(bus.waddr) < NREG) rf_d[bus.waddr] = bus.wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            slot_q      <= '0;
            err_q       <= '0;
            rf_q        <= '{default: '0};
        end else begin
            out_valid_q <= out_valid_d;
            slot_q      <= slot_d;
            err_q       <= err_d;
            rf_q        <= rf_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.opcode    = slot_q.opcode;
    assign bus.func      = slot_q.func;
    assign bus.rs1       = slot_q.rs1;
    assign bus.rs2       = slot_q.rs2;
    assign bus.rd        = slot_q.rd;
    assign bus.rs1_data  = slot_q.rs1_data;
    assign bus.rs2_data  = slot_q.rs2_data;
    assign bus.imm       = slot_q.imm;
    assign bus.hata      = slot_q.hata;
    assign bus.err_count = err_q;
endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb_decode_stage_pipe: two decode stages (sign-extend/32 regs and zero-extend/16 regs) against a behavioural model
module tb_decode_stage_pipe;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0, we = 1'b0, out_ready = 1'b1;
    logic [31:0] komut = '0, wdata = '0;
    logic [4:0]  waddr = '0;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    decode_stage_pipe_if #(.XLEN(32), .NREG(32), .ERRCNT_W(8)) b0 ();
    decode_stage_pipe_if #(.XLEN(32), .NREG(16), .ERRCNT_W(8)) b1 ();

    assign b0.in_valid  = in_valid;
    assign b0.komut     = komut;
    assign b0.we        = we;
    assign b0.waddr     = waddr;
    assign b0.wdata     = wdata;
    assign b0.out_ready = out_ready;
    assign b1.in_valid  = in_valid;
    assign b1.komut     = komut;
    assign b1.we        = we && waddr < 5'd16;
    assign b1.waddr     = waddr[3:0];
    assign b1.wdata     = wdata;
    assign b1.out_ready = out_ready;

    decode_stage_pipe #(.XLEN(32), .NREG(32), .SIGN_EXT(1), .ERRCNT_W(8)) u0 (.clk(clk), .reset(reset), .bus(b0));
    decode_stage_pipe #(.XLEN(32), .NREG(16), .SIGN_EXT(0), .ERRCNT_W(8)) u1 (.clk(clk), .reset(reset), .bus(b1));

    typedef struct packed {
        logic [6:0]  op;
        logic [3:0]  fn;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm;
        logic        h;
    } slot_t;

    slot_t       mslot [2];
    logic        mvalid [2];
    int          merr [2];
    logic [31:0] mregs [2][32];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mread(input int d, input logic [4:0] i);
        int nreg = (d == 0) ? 32 : 16;
        if (i == 0 || int'(i) >= nreg) return 32'h0;
        if (we && int'(waddr) == int'(i) && int'(waddr) < nreg) return wdata;
        return mregs[d][i];
    endfunction

    function automatic slot_t mdec(input int d, input logic [31:0] k);
        slot_t s = '0;
        int    nreg = (d == 0) ? 32 : 16;
        bit    sext = (d == 0);
        int    v;
        s.op = k[6:0];
        case (k[6:0])
            7'h01: begin
                s.rs1 = k[19:15]; s.rs2 = k[24:20]; s.rd = k[11:7];
                s.fn = 4'(k[14:12]) + (k[30] ? 4'd8 : 4'd0);
            end
            7'h03: begin
                s.rs1 = k[19:15]; s.rd = k[11:7]; s.fn = 4'(k[14:12]);
                v = int'(k[31:20]);
                if (sext && k[31]) v -= 4096;
                s.imm = 32'(v);
            end
            7'h07: begin
                s.rd = k[11:7]; s.imm = k >> 12;
            end
            7'h0F: begin
                s.rs1 = k[19:15]; s.rs2 = k[24:20]; s.fn = 4'(k[14:12]);
                v = int'({k[31:25], k[11:7]}) * 2;
                if (sext && k[31]) v -= 8192;
                s.imm = 32'(v);
            end
            default: s.h = 1'b1;
        endcase
        if (int'(s.rs1) >= nreg || int'(s.rs2) >= nreg || int'(s.rd) >= nreg) s.h = 1'b1;
        s.d1 = mread(d, s.rs1);
        s.d2 = mread(d, s.rs2);
        return s;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int d = 0; d < 2; d++) begin
                mvalid[d] = 1'b0; mslot[d] = '0; merr[d] = 0;
                for (int i = 0; i < 32; i++) mregs[d][i] = '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (in_valid && (!mvalid[d] || out_ready)) begin
                    mslot[d] = mdec(d, komut);
                    mvalid[d] = 1'b1;
                    if (mslot[d].h && merr[d] < 255) merr[d]++;
                end else if (out_ready) mvalid[d] = 1'b0;
                if (we && waddr != 0 && int'(waddr) < ((d == 0) ? 32 : 16)) mregs[d][waddr] = wdata;
            end
        end
    end

    task automatic cmp(input int d, input logic ov, input logic ir, input logic [6:0] op, input logic [3:0] fn,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdd, input logic [31:0] v1,
                       input logic [31:0] v2, input logic [31:0] im, input logic h, input logic [7:0] ec);
        string p = (d == 0) ? "u0" : "u1";
        chk({p, ".out_valid"}, ov, mvalid[d]);
        chk({p, ".in_ready"}, ir, !mvalid[d] || out_ready);
        chk({p, ".err_count"}, ec, merr[d]);
        if (mvalid[d]) begin
            chk({p, ".opcode"}, op, mslot[d].op);
            chk({p, ".func"}, fn, mslot[d].fn);
            chk({p, ".rs1"}, r1, mslot[d].rs1);
            chk({p, ".rs2"}, r2, mslot[d].rs2);
            chk({p, ".rd"}, rdd, mslot[d].rd);
            chk({p, ".rs1_data"}, v1, mslot[d].d1);
            chk({p, ".rs2_data"}, v2, mslot[d].d2);
            chk({p, ".imm"}, im, mslot[d].imm);
            chk({p, ".hata"}, h, mslot[d].h);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (!reset) begin
            cmp(0, b0.out_valid, b0.in_ready, b0.opcode, b0.func, b0.rs1, b0.rs2, b0.rd,
                b0.rs1_data, b0.rs2_data, b0.imm, b0.hata, b0.err_count);
            cmp(1, b1.out_valid, b1.in_ready, b1.opcode, b1.func, b1.rs1, b1.rs2, b1.rd,
                b1.rs1_data, b1.rs2_data, b1.imm, b1.hata, b1.err_count);
        end
    end

    task automatic wr(input logic [4:0] a, input logic [31:0] v);
        we = 1'b1; waddr = a; wdata = v; in_valid = 1'b0;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic issue(input logic [31:0] k);
        in_valid = 1'b1; komut = k;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [31:0] kb, koor, ka, kbb, kx5, kx0;
        kb   = {7'b1000000, 5'd6, 5'd5, 3'b001, 5'b00010, 7'b0001111};
        koor = {7'b0, 5'd6, 5'd20, 3'b000, 5'd3, 7'b0000001};
        ka   = {20'hABCDE, 5'd7, 7'b0000111};
        kbb  = {12'h123, 5'd5, 3'b010, 5'd9, 7'b0000011};
        kx5  = {12'h000, 5'd5, 3'b000, 5'd1, 7'b0000011};
        kx0  = {12'h000, 5'd0, 3'b000, 5'd1, 7'b0000011};
        #1 reset = 1'b1;
        #1;
        chk("rst.u0.out_valid", b0.out_valid, 0);
        chk("rst.u0.err_count", b0.err_count, 0);
        chk("rst.u0.rs1_data", b0.rs1_data, 0);
        chk("rst.u0.imm", b0.imm, 0);
        chk("rst.u1.out_valid", b1.out_valid, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        wr(5'd5, 32'h0000_1234);
        wr(5'd6, 32'h0000_0055);
        issue(32'h4062_8181);
        chk("r.out_valid", b0.out_valid, 1);
        chk("r.rd", b0.rd, 3);
        chk("r.rs1", b0.rs1, 5);
        chk("r.rs2", b0.rs2, 6);
        chk("r.func", b0.func, 4'b1000);
        chk("r.rs1_data", b0.rs1_data, 32'h1234);
        chk("r.rs2_data", b0.rs2_data, 32'h55);
        chk("r.imm", b0.imm, 0);
        chk("r.hata", b0.hata, 0);

        issue(32'hFFF0_0003);
        chk("i.sext.imm", b0.imm, 32'hFFFF_FFFF);
        chk("i.zext.imm", b1.imm, 32'h0000_0FFF);
        chk("i.rs2", b0.rs2, 0);
        issue(kb);
        chk("b.sext.imm", b0.imm, 32'hFFFF_F004);
        chk("b.zext.imm", b1.imm, 32'h0000_1004);
        chk("b.func", b0.func, 1);
        chk("b.rd", b0.rd, 0);

        wr(5'd20, 32'h77);
        issue(koor);
        chk("oor.u0.hata", b0.hata, 0);
        chk("oor.u0.rs1_data", b0.rs1_data, 32'h77);
        chk("oor.u1.hata", b1.hata, 1);
        chk("oor.u1.rs1", b1.rs1, 20);
        chk("oor.u1.rs1_data", b1.rs1_data, 0);
        chk("oor.u1.rs2_data", b1.rs2_data, 32'h55);

        idle();
        out_ready = 1'b0; in_valid = 1'b1; komut = ka;
        @(negedge clk);
        chk("u.imm", b0.imm, 32'h000A_BCDE);
        komut = kbb;
        repeat (3) begin
            #1;
            chk("stall.in_ready", b0.in_ready, 0);
            chk("stall.rd", b0.rd, 7);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1 chk("stall.release.in_ready", b0.in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("stall.second.rd", b0.rd, 9);
        chk("stall.second.imm", b0.imm, 32'h123);
        chk("stall.second.rs1_data", b0.rs1_data, 32'h1234);

        in_valid = 1'b1; komut = kx5; we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        we = 1'b0; in_valid = 1'b0;
        chk("byp.u0.rs1_data", b0.rs1_data, 32'hDEAD_BEEF);
        chk("byp.u1.rs1_data", b1.rs1_data, 32'hDEAD_BEEF);
        in_valid = 1'b1; komut = kx0; we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        we = 1'b0; in_valid = 1'b0;
        chk("x0.bypass.rs1_data", b0.rs1_data, 0);
        issue(kx0);
        chk("x0.read.rs1_data", b0.rs1_data, 0);
        issue(kx5);
        chk("x5.kept.rs1_data", b0.rs1_data, 32'hDEAD_BEEF);

        issue(32'h0000_007F);
        chk("ill.hata", b0.hata, 1);
        chk("ill.opcode", b0.opcode, 7'h7F);
        chk("ill.err_count", b0.err_count, 1);
        repeat (299) issue(32'h0000_007F);
        chk("sat.u0.err_count", b0.err_count, 8'hFF);
        chk("sat.u1.err_count", b1.err_count, 8'hFF);

        idle();
        out_ready = 1'b0;
        issue(32'h0000_007F);
        chk("pre_rst.out_valid", b0.out_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst.u0.out_valid", b0.out_valid, 0);
        chk("async_rst.u0.err_count", b0.err_count, 0);
        chk("async_rst.u1.out_valid", b1.out_valid, 0);
        chk("async_rst.u1.err_count", b1.err_count, 0);
        chk("async_rst.u0.hata", b0.hata, 0);
        @(negedge clk);
        reset = 1'b0; out_ready = 1'b1;
        issue(kx5);
        chk("post_rst.rs1_data", b0.rs1_data, 0);
        idle();
        idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
